simple_comp_feeder: RTL and testbench

- Upstream operand stage for simple_comp.
- Buffers operand triples (a, b, c) arriving on a valid/ready stream.
- Waits for simple_comp to report rdy, then drives each triple onto its a_in/b_in/c_in. Holds operands stable for a fixed latency, captures d_out and presents it on a valid/ready result stream.
- Serialises one operation at a time; simple_comp has no handshake of its own.

---
 rtl/simple_comp_feeder_pkg.sv | 20 ++
 rtl/simple_comp_feeder_if.sv | 54 +++++
 rtl/simple_comp_feeder_fifo.sv | 58 +++++
 rtl/simple_comp_feeder.sv | 168 ++++++++++++++++
 tb/tb_simple_comp_feeder.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simple_comp_feeder_pkg.sv
// Shared types for the simple_comp operand feeder: FSM states,
// default data width and the operand-triple bundle.
package simple_comp_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        S_BOOT,
        S_IDLE,
        S_WAIT,
        S_OUT
    } state_t;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
        logic [DEF_WIDTH-1:0] c;
    } triple_t;

endpackage

// File: rtl/simple_comp_feeder_if.sv
// Bus bundle of simple_comp_feeder: operand stream, simple_comp link,
// result stream and status. slave = feeder side, master = environment.
// Stats ports ops_done/replays exist only with SIMPLE_COMP_FEEDER_STATS_EN.
interface simple_comp_feeder_if
    import simple_comp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic             comp_rdy;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] c_out;
    logic [WIDTH-1:0] comp_d;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [CW-1:0]    fifo_count;
    logic             busy;
`ifdef SIMPLE_COMP_FEEDER_STATS_EN
    logic [31:0]      ops_done;
    logic [15:0]      replays;
`endif

    modport slave (
        input  in_valid, in_a, in_b, in_c,
        input  comp_rdy, comp_d, res_ready,
        output in_ready, a_out, b_out, c_out,
        output res_valid, res_data,
        output fifo_count, busy
`ifdef SIMPLE_COMP_FEEDER_STATS_EN
        , output ops_done, replays
`endif
    );

    modport master (
        output in_valid, in_a, in_b, in_c,
        output comp_rdy, comp_d, res_ready,
        input  in_ready, a_out, b_out, c_out,
        input  res_valid, res_data,
        input  fifo_count, busy
`ifdef SIMPLE_COMP_FEEDER_STATS_EN
        , input ops_done, replays
`endif
    );

endinterface

// File: rtl/simple_comp_feeder_fifo.sv
// simple_comp_fifo: synchronous first-word-fall-through FIFO.
// Ports: clock, rst, push/wdata, pop/rdata, full, empty, count.
module simple_comp_fifo #(
    parameter  int WIDTH = 48,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by overflow.
    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/simple_comp_feeder.sv
// simple_comp_feeder: buffers operand triples, drives them into
// simple_comp one at a time, waits LATENCY edges and returns d_out.
// Ports: clock, rst (sync, active-high), bus (simple_comp_feeder_if.slave).
// Optional SIMPLE_COMP_FEEDER_STATS_EN adds ops_done and replays counters.
module simple_comp_feeder
    import simple_comp_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic                 clock,
    input  logic                 rst,
    simple_comp_feeder_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int LW = $clog2(LATENCY + 1);
    localparam int TW = 3 * WIDTH;

    state_t           state;
    logic             replay;
    logic [LW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] res_q;
    logic             res_v;
    logic             busy_q;

    logic [TW-1:0]    head;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    logic             accept;
    logic             abort;

    assign push   = bus.in_valid && !full;
    assign accept = res_v && bus.res_ready;
    assign abort  = (state == S_WAIT) && !bus.comp_rdy;

    // Pop from IDLE, or back-to-back on the result accept edge.
    assign pop = !empty && bus.comp_rdy &&
                 ((state == S_IDLE) ||
                  ((state == S_OUT) && accept));

    simple_comp_fifo #(
        .WIDTH (TW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (push),
        .wdata ({bus.in_a, bus.in_b, bus.in_c}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            state  <= S_BOOT;
            replay <= 1'b0;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            res_q  <= '0;
            res_v  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            unique case (state)
                S_BOOT: begin
                    // Replay re-runs the retained operands.
                    if (bus.comp_rdy) begin
                        if (replay) begin
                            state  <= S_WAIT;
                            cnt    <= LW'(LATENCY);
                            replay <= 1'b0;
                            busy_q <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_IDLE: begin
                    if (!bus.comp_rdy) begin
                        state <= S_BOOT;
                    end else if (pop) begin
                        {a_q, b_q, c_q} <= head;
                        cnt    <= LW'(LATENCY);
                        state  <= S_WAIT;
                        busy_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!bus.comp_rdy) begin
                        state  <= S_BOOT;
                        replay <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == LW'(1)) begin
                            res_q <= bus.comp_d;
                            res_v <= 1'b1;
                            state <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (accept) begin
                        res_v <= 1'b0;
                        if (pop) begin
                            {a_q, b_q, c_q} <= head;
                            cnt   <= LW'(LATENCY);
                            state <= S_WAIT;
                        end else begin
                            a_q    <= '0;
                            b_q    <= '0;
                            c_q    <= '0;
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

    assign bus.in_ready   = !full;
    assign bus.a_out      = a_q;
    assign bus.b_out      = b_q;
    assign bus.c_out      = c_q;
    assign bus.res_valid  = res_v;
    assign bus.res_data   = res_q;
    assign bus.fifo_count = count;
    assign bus.busy       = busy_q;

`ifdef SIMPLE_COMP_FEEDER_STATS_EN
    logic [31:0] ops_q;
    logic [15:0] rep_q;

    always_ff @(posedge clock) begin
        if (rst) begin
            ops_q <= '0;
            rep_q <= '0;
        end else begin
            if (accept) begin
                ops_q <= ops_q + 1'b1;
            end
            if (abort && (rep_q != 16'hFFFF)) begin
                rep_q <= rep_q + 1'b1;
            end
        end
    end

    assign bus.ops_done = ops_q;
    assign bus.replays  = rep_q;
`else
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_simple_comp_feeder.sv
// Self-checking bench for simple_comp_feeder with a registered
// a+b+c stub standing in for simple_comp.
module tb_simple_comp_feeder;
    import simple_comp_pkg::*;

    logic clock = 1'b0;
    logic rst   = 1'b1;

    always #5 clock = ~clock;

    simple_comp_feeder_if #(.WIDTH(16), .DEPTH(4)) bus ();

    simple_comp_feeder #(
        .WIDTH   (16),
        .DEPTH   (4),
        .LATENCY (2)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always_ff @(posedge clock) begin
        bus.comp_d <= bus.a_out + bus.b_out + bus.c_out;
    end

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q [$];

    function automatic logic [15:0] model(input triple_t t);
        return t.a + t.b + t.c;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one triple for one edge; scoreboard it if accepted.
    task automatic drive(input triple_t t, output bit ok);
        bus.in_a     = t.a;
        bus.in_b     = t.b;
        bus.in_c     = t.c;
        bus.in_valid = 1'b1;
        ok = bus.in_ready;
        if (ok) exp_q.push_back(model(t));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks += 5;
        if (bus.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_res_valid got %0b want 0", bus.res_valid);
        end
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_in_ready got %0b want 1", bus.in_ready);
        end
        if (bus.fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL rst_count got %0d want 0", bus.fifo_count);
        end
        if (bus.a_out !== 16'h0 || bus.res_data !== 16'h0) begin
            failures++;
            $display("FAIL rst_data got %h/%h want 0/0",
                     bus.a_out, bus.res_data);
        end
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy got %0b want 0", bus.busy);
        end
    endtask

    task automatic test_boot_gating();
        triple_t t;
        bit ok;
        logic [15:0] e;
        bus.comp_rdy  = 1'b0;
        bus.res_ready = 1'b0;
        t = '{a: 16'h0fff, b: 16'h0fff, c: 16'h0fff};
        drive(t, ok);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.a_out !== 16'h0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL boot_gate cyc %0d a_out %h busy %0b want 0/0",
                         i, bus.a_out, bus.busy);
            end
            tick();
        end
        checks++;
        if (bus.fifo_count !== 3'd1) begin
            failures++;
            $display("FAIL boot_count got %0d want 1", bus.fifo_count);
        end
        bus.comp_rdy = 1'b1;
        tick();
        checks++;
        if (bus.a_out !== 16'h0) begin
            failures++;
            $display("FAIL boot_edge1 a_out %h want 0", bus.a_out);
        end
        tick();
        checks++;
        if (bus.a_out !== 16'h0fff || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL boot_load a_out %h busy %0b want 0fff/1",
                     bus.a_out, bus.busy);
        end
        tick();
        checks++;
        if (bus.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL boot_early valid %0b want 0", bus.res_valid);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== e) begin
            failures++;
            $display("FAIL boot_result valid %0b data %h want 1/%h",
                     bus.res_valid, bus.res_data, e);
        end
        bus.res_ready = 1'b1;
        tick();
        checks++;
        if (bus.res_valid !== 1'b0 || bus.a_out !== 16'h0) begin
            failures++;
            $display("FAIL boot_accept valid %0b a_out %h want 0/0",
                     bus.res_valid, bus.a_out);
        end
    endtask

    task automatic test_latency();
        triple_t t;
        bit ok;
        logic [15:0] e;
        bus.comp_rdy  = 1'b1;
        bus.res_ready = 1'b1;
        t = '{a: 16'h0666, b: 16'h0666, c: 16'h0666};
        drive(t, ok);
        checks++;
        if (bus.a_out !== 16'h0) begin
            failures++;
            $display("FAIL lat_p a_out %h want 0", bus.a_out);
        end
        tick();
        checks++;
        if (bus.a_out !== 16'h0666 || bus.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_p1 a_out %h valid %0b want 0666/0",
                     bus.a_out, bus.res_valid);
        end
        tick();
        checks++;
        if (bus.res_valid !== 1'b0) begin
            failures++;
            $display("FAIL lat_p2 valid %0b want 0", bus.res_valid);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== e ||
            e !== 16'h1332) begin
            failures++;
            $display("FAIL lat_p3 valid %0b data %h want 1/1332",
                     bus.res_valid, bus.res_data);
        end
        tick();
        checks++;
        if (bus.res_valid !== 1'b0 || bus.a_out !== 16'h0) begin
            failures++;
            $display("FAIL lat_accept valid %0b a_out %h want 0/0",
                     bus.res_valid, bus.a_out);
        end
    endtask

    task automatic test_full();
        triple_t t;
        bit ok;
        int acc;
        int got;
        int last;
        logic [15:0] e;
        bus.comp_rdy  = 1'b1;
        bus.res_ready = 1'b0;
        acc = 0;
        for (int i = 1; i <= 6; i++) begin
            t = '{a: 16'(i), b: 16'(2 * i), c: 16'(3 * i + 16'h100)};
            drive(t, ok);
            if (ok) acc++;
        end
        checks += 3;
        if (acc != 5) begin
            failures++;
            $display("FAIL full_accepted got %0d want 5", acc);
        end
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_in_ready got %0b want 0", bus.in_ready);
        end
        if (bus.fifo_count !== 3'd4) begin
            failures++;
            $display("FAIL full_count got %0d want 4", bus.fifo_count);
        end
        bus.res_ready = 1'b1;
        got  = 0;
        last = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            if (bus.res_valid === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.res_data !== e) begin
                    failures++;
                    $display("FAIL full_order #%0d got %h want %h",
                             got, bus.res_data, e);
                end
                if (got > 0) begin
                    checks++;
                    if (c - last != 3) begin
                        failures++;
                        $display("FAIL full_spacing #%0d got %0d want 3",
                                 got, c - last);
                    end
                end
                last = c;
                got++;
            end
            tick();
        end
        checks++;
        if (got != 5) begin
            failures++;
            $display("FAIL full_timeout got %0d results want 5", got);
        end
    endtask

    task automatic test_replay();
        triple_t t;
        bit ok;
        int got;
        logic [15:0] e;
        bus.comp_rdy  = 1'b1;
        bus.res_ready = 1'b1;
        t = '{a: 16'h0001, b: 16'h0002, c: 16'h0003};
        drive(t, ok);
        tick();
        bus.comp_rdy = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.a_out !== 16'h0001) begin
            failures++;
            $display("FAIL replay_abort busy %0b a_out %h want 0/0001",
                     bus.busy, bus.a_out);
        end
        tick();
        bus.comp_rdy = 1'b1;
        tick();
        got = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.res_valid === 1'b1) begin
                got++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL replay_extra got %h want none",
                             bus.res_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.res_data !== e || e !== 16'h0006) begin
                        failures++;
                        $display("FAIL replay_data got %h want 0006",
                                 bus.res_data);
                    end
                end
            end
            tick();
        end
        checks++;
        if (got != 1) begin
            failures++;
            $display("FAIL replay_count got %0d want 1", got);
        end
`ifdef SIMPLE_COMP_FEEDER_STATS_EN
        checks += 2;
        if (bus.replays !== 16'd1) begin
            failures++;
            $display("FAIL stats_replays got %0d want 1", bus.replays);
        end
        if (bus.ops_done !== 32'd8) begin
            failures++;
            $display("FAIL stats_ops got %0d want 8", bus.ops_done);
        end
`endif
    endtask

    task automatic test_reset_mid();
        triple_t t;
        bit ok;
        int stale;
        int w;
        bus.comp_rdy  = 1'b1;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            t = '{a: 16'(16'h20 + i), b: 16'h1, c: 16'h1};
            drive(t, ok);
        end
        w = 0;
        while (bus.res_valid !== 1'b1 && w < 10) begin
            tick();
            w++;
        end
        checks++;
        if (bus.res_valid !== 1'b1 || bus.fifo_count !== 3'd2) begin
            failures++;
            $display("FAIL mid_setup valid %0b count %0d want 1/2",
                     bus.res_valid, bus.fifo_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        checks++;
        if (bus.res_valid !== 1'b0 || bus.fifo_count !== 3'd0 ||
            bus.a_out !== 16'h0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset valid %0b cnt %0d a %h rdy %0b",
                     bus.res_valid, bus.fifo_count, bus.a_out,
                     bus.in_ready);
        end
        bus.res_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.res_valid === 1'b1) stale++;
        end
        checks++;
        if (stale != 0) begin
            failures++;
            $display("FAIL mid_stale got %0d results want 0", stale);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_c      = '0;
        bus.comp_rdy  = 1'b0;
        bus.res_ready = 1'b0;
        test_reset();
        test_boot_gating();
        test_latency();
        test_full();
        test_replay();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
